display_scheduler: RTL and testbench

Sequencer that time-shares the six-digit seven-segment display between up to NSRC signed binary sources, such as pipeline registers, ALU result and PC. It picks one source at a time in round-robin order and converts its magnitude to packed BCD with an iterative shift-add-3 (double-dabble) engine. It then drives the 24-bit digit word and sign bit consumed by `displays`, and emits the display's special codes for overflow (0xFFFFFF) and no-data (0xFFFFFE).

---
 rtl/display_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_display_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler
//   Time-shares a six-digit seven-segment display between NSRC signed
//   sources. Sources are visited in round-robin order over the enabled set;
//   the selected value's magnitude is converted to packed BCD with a
//   shift-add-3 engine running exactly W cycles, then presented together
//   with its sign. Magnitudes above 999999 show the overflow code 0xFFFFFF;
//   with no source enabled the no-data code 0xFFFFFE is shown.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   src_val    in   NSRC*W packed sources, source i at [i*W +: W]
//   src_en     in   per-source enable mask
//   next       in   one-cycle pulse: advance to the next enabled source
//   hold       in   level: suppress dwell-driven advance (refresh continues)
//   n          out  BCD digit word, digit 5 at [23:20]
//   sign       out  1 = displayed value is negative
//   sel        out  index of the source shown
//   busy       out  high in LOAD, CONV, PRESENT
//   dbg_state  out  current FSM state encoding
//
// Control semantics: next and hold are plain levels sampled on every clock.
// A next pulse seen while a conversion is in flight is remembered as one
// pending advance (further pulses merge into it) and takes effect on the
// first WAIT cycle. In WAIT, next advances immediately; a dwell expiry in
// the same cycle does not add a second advance.
module display_scheduler #(
  parameter int NSRC  = 4,
  parameter int W     = 24,
  parameter int DWELL = 50_000_000,
  localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int DW   = $clog2(DWELL),
  localparam int CW   = $clog2(W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC*W-1:0]  src_val,
  input  logic [NSRC-1:0]    src_en,
  input  logic               next,
  input  logic               hold,
  output logic [23:0]        n,
  output logic               sign,
  output logic [SW-1:0]      sel,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CONV    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  localparam logic [23:0] CODE_OVF    = 24'hFFFFFF;
  localparam logic [23:0] CODE_NODATA = 24'hFFFFFE;

  logic [2:0]    state_q,  state_d;
  logic [SW-1:0] sel_q,    sel_d;
  logic [23:0]   n_q,      n_d;
  logic          sign_q,   sign_d;
  logic          sign_r_q, sign_r_d;
  logic          ovf_q,    ovf_d;
  logic [W-1:0]  mag_q,    mag_d;
  logic [23:0]   bcd_q,    bcd_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [DW-1:0] dwell_q,  dwell_d;
  logic          pend_q,   pend_d;

  logic [SW-1:0] first_sel;
  logic [SW-1:0] hi_sel;
  logic          any_hi;
  logic [SW-1:0] nxt_sel;
  logic [W-1:0]  src_word;
  logic [W-1:0]  abs_word;
  logic [23:0]   bcd_adj;
  logic          expire;

  always_comb begin
    // Lowest enabled index, and lowest enabled index strictly above sel.
    // Descending scan so the smallest match is the one that sticks.
    first_sel = '0;
    hi_sel    = '0;
    any_hi    = 1'b0;
    src_word  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_en[SW'(i)]) begin
        first_sel = SW'(i);
        if (SW'(i) > sel_q) begin
          hi_sel = SW'(i);
          any_hi = 1'b1;
        end
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (SW'(i) == sel_q) src_word = src_val[i*W +: W];
    end
    // Wrap to the lowest enabled index; lands back on sel when it is the
    // only enabled source.
    nxt_sel = any_hi ? hi_sel : first_sel;

    // Two's-complement magnitude; the most negative value maps to 2^(W-1)
    // as an unsigned W-bit number.
    abs_word = src_word[W-1] ? (~src_word + 1'b1) : src_word;

    for (int d = 0; d < 6; d++) begin
      bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? (bcd_q[4*d +: 4] + 4'd3)
                                                     : bcd_q[4*d +: 4];
    end

    expire = (dwell_q == DW'(DWELL - 1));

    state_d  = state_q;
    sel_d    = sel_q;
    n_d      = n_q;
    sign_d   = sign_q;
    sign_r_d = sign_r_q;
    ovf_d    = ovf_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    pend_d   = pend_q;

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (src_en == '0) begin
          n_d    = CODE_NODATA;
          sign_d = 1'b0;
        end else begin
          sel_d   = first_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pend_d   = pend_q | next;
        sign_r_d = src_word[W-1];
        mag_d    = abs_word;
        ovf_d    = (abs_word > W'(999999));
        bcd_d    = '0;
        cnt_d    = '0;
        state_d  = S_CONV;
      end
      S_CONV: begin
        pend_d = pend_q | next;
        // Always W iterations, overflow or not, so latency is constant.
        {bcd_d, mag_d} = {bcd_adj[22:0], mag_q, 1'b0};
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESENT: begin
        pend_d  = pend_q | next;
        n_d     = ovf_q ? CODE_OVF : bcd_q;
        sign_d  = sign_r_q;
        dwell_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        pend_d  = 1'b0;
        dwell_d = dwell_q + 1'b1;
        if (src_en == '0) begin
          state_d = S_IDLE;
        end else if (pend_q || next || (expire && !hold)) begin
          sel_d   = nxt_sel;
          state_d = S_LOAD;
        end else if (expire) begin
          // Held refresh: same source if it is still enabled.
          sel_d   = src_en[sel_q] ? sel_q : nxt_sel;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      n_q      <= CODE_NODATA;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      ovf_q    <= 1'b0;
      mag_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      n_q      <= n_d;
      sign_q   <= sign_d;
      sign_r_q <= sign_r_d;
      ovf_q    <= ovf_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      pend_q   <= pend_d;
    end
  end

  assign n         = n_q;
  assign sign      = sign_q;
  assign sel       = sel_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_CONV) || (state_q == S_PRESENT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//   Bench for display_scheduler with NSRC=4, W=24, DWELL=40. Inputs are
//   driven and outputs sampled on the falling clock edge. Each presented
//   value is compared against a {sel, sign, n} entry pushed to exp_q when
//   the corresponding source value was driven; the expected BCD comes from a
//   decimal-digit model independent of the shift-add-3 engine.
module tb_display_scheduler;
  localparam int NSRC  = 4;
  localparam int W     = 24;
  localparam int DWELL = 40;
  localparam int SW    = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CONV    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC*W-1:0] src_val;
  logic [NSRC-1:0]   src_en;
  logic              next;
  logic              hold;
  logic [23:0]       n;
  logic              sign;
  logic [SW-1:0]     sel;
  logic              busy;
  logic [2:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [26:0] exp_q[$];

  display_scheduler #(.NSRC(NSRC), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .src_val(src_val), .src_en(src_en),
    .next(next), .hold(hold), .n(n), .sign(sign), .sel(sel),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- model / driver ----------------
  function automatic logic [24:0] model(input logic [23:0] v);
    logic [23:0] mag;
    logic [23:0] r;
    int m;
    mag = v[23] ? 24'(-v) : v;
    r = '0;
    if (mag > 24'd999999) return {v[23], 24'hFFFFFF};
    m = int'(mag);
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {v[23], r};
  endfunction

  task automatic set_src(input int i, input int v);
    src_val[i*W +: W] = v[23:0];
  endtask

  task automatic push_exp(input int i);
    logic [24:0] m;
    m = model(src_val[i*W +: W]);
    exp_q.push_back({SW'(i), m});
  endtask

  task automatic pulse_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  // Waits for the next PRESENT cycle and returns one falling edge later,
  // when n/sign have taken the new value. cycles counts falling edges
  // advanced; busy_cnt counts busy samples; early flags any n change
  // before PRESENT.
  task automatic wait_present(output int cycles, output int busy_cnt,
                              output bit early, output bit ok);
    logic [23:0] n0;
    n0 = n;
    cycles = 0;
    busy_cnt = 0;
    early = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (busy) busy_cnt++;
      if (dbg_state == S_PRESENT) begin
        @(negedge clk);
        cycles++;
        ok = 1'b1;
        break;
      end
      if (n !== n0) early = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    src_en = '0; src_val = '0; next = 1'b0; hold = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({n, sign, sel, busy, dbg_state} !== {24'hFFFFFE, 1'b0, 2'd0, 1'b0, S_IDLE}) begin
      tests_failed++;
      $display("FAIL reset_values: n=%h sign=%b sel=%0d busy=%b st=%0d, want n=fffffe sign=0 sel=0 busy=0 st=0",
               n, sign, sel, busy, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({n, sign, busy, dbg_state} !== {24'hFFFFFE, 1'b0, 1'b0, S_IDLE}) begin
      tests_failed++;
      $display("FAIL idle_no_src: n=%h sign=%b busy=%b st=%0d, want n=fffffe sign=0 busy=0 st=0",
               n, sign, busy, dbg_state);
    end
  endtask

  task automatic test_basic();
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    src_en = 4'b0001;
    set_src(0, 123456);
    do_reset();
    push_exp(0);
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp) begin
      tests_failed++;
      $display("FAIL basic_value: got %h want %h ok=%b", got, exp, ok);
    end
    tests_run++;
    if (cyc != 27 || bc != 26) begin
      tests_failed++;
      $display("FAIL basic_latency: cycles=%0d busy=%0d, want 27 and 26", cyc, bc);
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL basic_partial: n changed before PRESENT, want stable");
    end
  endtask

  task automatic test_values();
    int vals[8];
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    vals = '{-42, 999999, 1000000, -8388608, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) vals[i] = int'($urandom_range(0, 2_000_000)) - 1_000_000;
    for (int i = 0; i < 8; i++) begin
      set_src(0, vals[i]);
      push_exp(0);
      wait_present(cyc, bc, early, ok);
      got = {sel, sign, n};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
      tests_run++;
      if (!ok || got !== exp || cyc != 66) begin
        tests_failed++;
        $display("FAIL value_%0d: got %h cycles=%0d, want %h cycles=66 (src=%0d)",
                 i, got, cyc, exp, vals[i]);
      end
    end
  endtask

  task automatic test_rotation();
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    int order[4];
    order = '{1, 3, 1, 3};
    src_en = 4'b1010;
    set_src(0, 11); set_src(1, 222); set_src(2, 3333); set_src(3, -44444);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(order[i]);
      wait_present(cyc, bc, early, ok);
      got = {sel, sign, n};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
      tests_run++;
      if (!ok || got !== exp || cyc != ((i == 0) ? 27 : 66)) begin
        tests_failed++;
        $display("FAIL rotation_%0d: got %h cycles=%0d, want %h cycles=%0d",
                 i, got, cyc, exp, (i == 0) ? 27 : 66);
      end
    end
  endtask

  task automatic test_next_hold();
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    src_en = 4'b1111;
    set_src(0, 100); set_src(1, -201); set_src(2, 302); set_src(3, 403);
    do_reset();
    push_exp(0);
    repeat (5) @(negedge clk);
    pulse_next();
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp || dbg_state !== S_WAIT) begin
      tests_failed++;
      $display("FAIL next_first: got %h st=%0d, want %h st=4", got, dbg_state, exp);
    end
    @(negedge clk);
    tests_run++;
    if (dbg_state !== S_LOAD || sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL next_advance: st=%0d sel=%0d, want st=1 sel=1", dbg_state, sel);
    end
    push_exp(1);
    repeat (3) @(negedge clk);
    pulse_next();
    repeat (2) @(negedge clk);
    pulse_next();
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp) begin
      tests_failed++;
      $display("FAIL next_sel1: got %h want %h", got, exp);
    end
    push_exp(2);
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp || cyc != 27) begin
      tests_failed++;
      $display("FAIL next_double_collapse: got %h cycles=%0d, want %h cycles=27", got, cyc, exp);
    end
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_src(2, 765432 - i * 111111);
      push_exp(2);
      wait_present(cyc, bc, early, ok);
      got = {sel, sign, n};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
      tests_run++;
      if (!ok || got !== exp || cyc != 66) begin
        tests_failed++;
        $display("FAIL hold_refresh_%0d: got %h cycles=%0d, want %h cycles=66", i, got, cyc, exp);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_disable();
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    repeat (3) @(negedge clk);
    src_en = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL disable_state: st=%0d, want 0", dbg_state);
    end
    @(negedge clk);
    tests_run++;
    if ({n, sign, busy} !== {24'hFFFFFE, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL disable_nodata: n=%h sign=%b busy=%b, want fffffe 0 0", n, sign, busy);
    end
    src_en = 4'b0100;
    set_src(2, -90817);
    push_exp(2);
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp || cyc != 27) begin
      tests_failed++;
      $display("FAIL reenable: got %h cycles=%0d, want %h cycles=27", got, cyc, exp);
    end
  endtask

  task automatic test_reset_mid_conv();
    int cyc, bc; bit early, ok; logic [26:0] got, exp;
    src_en = 4'b0010;
    set_src(1, 654321);
    do_reset();
    repeat (12) @(negedge clk);
    tests_run++;
    if (dbg_state !== S_CONV || sel !== 2'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midconv_setup: st=%0d sel=%0d busy=%b, want st=2 sel=1 busy=1", dbg_state, sel, busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({n, sign, sel, busy, dbg_state} !== {24'hFFFFFE, 1'b0, 2'd0, 1'b0, S_IDLE}) begin
      tests_failed++;
      $display("FAIL midconv_async_reset: n=%h sign=%b sel=%0d busy=%b st=%0d, want fffffe 0 0 0 0",
               n, sign, sel, busy, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    push_exp(1);
    wait_present(cyc, bc, early, ok);
    got = {sel, sign, n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'h0;
    tests_run++;
    if (!ok || got !== exp || cyc != 27) begin
      tests_failed++;
      $display("FAIL midconv_recover: got %h cycles=%0d, want %h cycles=27", got, cyc, exp);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    src_en = '0; src_val = '0; next = 1'b0; hold = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_values();
    test_rotation();
    test_next_hold();
    test_disable();
    test_reset_mid_conv();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
